// File: rtl/bus_dec_pkg.sv
// Shared types and default region map for the data-bus decoder.
// Slave indices double as bit positions in s_cs_n / s_ready.
package bus_dec_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

    localparam int unsigned DMEM  = 0;
    localparam int unsigned TBMAN = 1;
    localparam int unsigned GPIO  = 2;
    localparam int unsigned TIMER = 3;
    localparam int unsigned UART  = 4;

    // Listed from slave 4 down to slave 0.
    localparam logic [159:0] DEF_BASE = {32'h8000_0000, 32'h8000_1000, 32'h8000_2000,
                                         32'h8000_F000, 32'h1000_0000};
    // DMEM mask ignores bit 29 so both 0x1xxx_xxxx and 0x3xxx_xxxx alias onto it.
    localparam logic [159:0] DEF_MASK = {{4{32'hFFFF_F000}}, 32'hD000_0000};

endpackage

// File: rtl/bus_dec_match.sv
// Combinational base/mask region compare with lowest-index-wins priority.
module bus_dec_match #(
    parameter int unsigned N_SLV = 5,
    parameter int unsigned AW = 32,
    parameter int unsigned SW = (N_SLV > 1) ? $clog2(N_SLV) : 1,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [SW-1:0] sel
);

    // Walk from the top so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                sel = SW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_decoder_fsm.sv
// Registered address decoder and response router between the MEM-stage port and the slaves.
// Unmapped or hung accesses complete with a bus error instead of stalling the core.
module bus_decoder_fsm
    import bus_dec_pkg::*;
#(
    parameter int unsigned N_SLV = 5,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = bus_dec_pkg::DEF_BASE,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = bus_dec_pkg::DEF_MASK,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m_req,
    input  logic [AW-1:0]       m_addr,
    input  logic                m_we,
    input  logic [DW-1:0]       m_wdata,
    input  logic [DW/8-1:0]     m_be,
    output logic                m_ready,
    output logic                m_err,
    output logic [DW-1:0]       m_rdata,
    output logic [N_SLV-1:0]    s_cs_n,
    output logic [AW-1:0]       s_addr,
    output logic                s_we,
    output logic [DW-1:0]       s_wdata,
    output logic [DW/8-1:0]     s_be,
    input  logic [N_SLV-1:0]    s_ready,
    input  logic [N_SLV*DW-1:0] s_rdata
);

    localparam int unsigned SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d, sel_m;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hit;
    logic            capture;
    logic            sel_ready;
    logic [DW-1:0]   sel_rdata;
    logic [N_SLV-1:0] cs_n_d;
    logic            m_ready_d, m_err_d;
    logic [DW-1:0]   m_rdata_d;

    bus_dec_match #(
        .N_SLV   (N_SLV),
        .AW      (AW),
        .SW      (SW),
        .SLV_BASE(SLV_BASE),
        .SLV_MASK(SLV_MASK)
    ) u_match (
        .addr(m_addr),
        .hit (hit),
        .sel (sel_m)
    );

    assign capture   = (state_q == IDLE) && m_req;
    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[int'(sel_q)*DW +: DW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            s_cs_n  <= '1;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            s_addr  <= '0;
            s_we    <= 1'b0;
            s_wdata <= '0;
            s_be    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            s_cs_n  <= cs_n_d;
            m_ready <= m_ready_d;
            m_err   <= m_err_d;
            m_rdata <= m_rdata_d;
            if (capture) begin
                s_addr  <= m_addr;
                s_we    <= m_we;
                s_wdata <= m_wdata;
                s_be    <= m_be;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    state_d = hit ? ACCESS : ERR;
                    sel_d   = sel_m;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                // A ready arriving on the last allowed cycle still completes normally.
                if (sel_ready) begin
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        cs_n_d    = '1;
        m_ready_d = 1'b0;
        m_err_d   = 1'b0;
        m_rdata_d = '0;
        unique case (state_d)
            ACCESS: cs_n_d[sel_d] = 1'b0;
            RESP: begin
                m_ready_d = 1'b1;
                m_rdata_d = s_we ? '0 : sel_rdata;
            end
            ERR: begin
                m_ready_d = 1'b1;
                m_err_d   = 1'b1;
                m_rdata_d = ERR_DATA;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_decoder_fsm.sv
// Randomised self-checking bench for bus_decoder_fsm against a region-table / latency model.
module tb_bus_decoder_fsm;

    localparam int unsigned TO = 4;
    localparam logic [159:0] OVR_BASE = {32'h8000_0000, 32'h8000_1000, 32'h8000_2000,
                                         32'h8000_F000, 32'h8000_0000};
    localparam logic [159:0] OVR_MASK = {{4{32'hFFFF_F000}}, 32'hFFFF_0000};
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         m_req = 1'b0;
    logic [31:0]  m_addr = '0;
    logic         m_we = 1'b0;
    logic [31:0]  m_wdata = '0;
    logic [3:0]   m_be = '0;
    logic [4:0]   s_ready = '0;
    logic [4:0]   s_ready2 = '0;
    logic [159:0] s_rdata = '0;

    logic         m_ready, m_err, s_we;
    logic [31:0]  m_rdata, s_addr, s_wdata;
    logic [4:0]   s_cs_n;
    logic [3:0]   s_be;
    logic         m_ready2, m_err2, s_we2;
    logic [31:0]  m_rdata2, s_addr2, s_wdata2;
    logic [4:0]   s_cs_n2;
    logic [3:0]   s_be2;

    int n_checks = 0;
    int n_pass = 0;

    int unsigned reg_base[5] = '{32'h1000_0000, 32'h8000_F000, 32'h8000_2000,
                                 32'h8000_1000, 32'h8000_0000};
    int unsigned reg_mask[5] = '{32'hD000_0000, 32'hFFFF_F000, 32'hFFFF_F000,
                                 32'hFFFF_F000, 32'hFFFF_F000};

    always #5 clk = ~clk;

    bus_decoder_fsm #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
        .m_wdata(m_wdata), .m_be(m_be), .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
        .s_cs_n(s_cs_n), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_be(s_be),
        .s_ready(s_ready), .s_rdata(s_rdata)
    );

    bus_decoder_fsm #(.TIMEOUT(TO), .SLV_BASE(OVR_BASE), .SLV_MASK(OVR_MASK)) dut_ovr (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
        .m_wdata(m_wdata), .m_be(m_be), .m_ready(m_ready2), .m_err(m_err2),
        .m_rdata(m_rdata2), .s_cs_n(s_cs_n2), .s_addr(s_addr2), .s_we(s_we2),
        .s_wdata(s_wdata2), .s_be(s_be2), .s_ready(s_ready2), .s_rdata(s_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int model_sel(input logic [31:0] a);
        for (int i = 0; i < 5; i++) begin
            if ((a & reg_mask[i]) == reg_base[i]) return i;
        end
        return -1;
    endfunction

    // lat = cycles the selected slave waits before ready; lat >= TO means it never answers.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] be, input int lat, input logic [31:0] rdata);
        int sel;
        int n_acc;
        logic [4:0] exp_cs;
        sel = model_sel(addr);
        m_req = 1'b1; m_addr = addr; m_we = we; m_wdata = wdata; m_be = be; s_ready = '0;
        @(posedge clk); #1;
        // Scramble the request lines; the captured copy must not move.
        m_addr = $urandom; m_we = ~we; m_wdata = $urandom; m_be = 4'($urandom);
        if (sel < 0) begin
            check_eq("miss_ready", 32'(m_ready), 32'd1);
            check_eq("miss_err", 32'(m_err), 32'd1);
            check_eq("miss_rdata", m_rdata, ERRD);
            check_eq("miss_cs", 32'(s_cs_n), 32'h1f);
        end else begin
            n_acc = (lat < int'(TO)) ? lat + 1 : int'(TO);
            exp_cs = 5'h1f;
            exp_cs[sel] = 1'b0;
            for (int c = 0; c < n_acc; c++) begin
                check_eq("acc_cs", 32'(s_cs_n), 32'(exp_cs));
                check_eq("acc_no_ready", 32'(m_ready), 32'd0);
                check_eq("acc_addr", s_addr, addr);
                check_eq("acc_we", 32'(s_we), 32'(we));
                check_eq("acc_wdata", s_wdata, wdata);
                check_eq("acc_be", 32'(s_be), 32'(be));
                s_ready = 5'($urandom) & exp_cs;
                s_ready[sel] = (c == lat);
                s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
                s_rdata[sel*32 +: 32] = rdata;
                @(posedge clk); #1;
            end
            check_eq("rsp_ready", 32'(m_ready), 32'd1);
            check_eq("rsp_err", 32'(m_err), 32'(lat >= int'(TO)));
            check_eq("rsp_rdata", m_rdata, (lat >= int'(TO)) ? ERRD : (we ? 32'd0 : rdata));
            check_eq("rsp_cs", 32'(s_cs_n), 32'h1f);
        end
        m_req = 1'b0; s_ready = '0;
        @(posedge clk); #1;
        check_eq("post_ready", 32'(m_ready), 32'd0);
        check_eq("post_cs", 32'(s_cs_n), 32'h1f);
    endtask

    task automatic run_random(input int n);
        int r;
        logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            r = $urandom_range(0, 5);
            if (r == 5) a = $urandom;
            else a = reg_base[r] | ($urandom & ~reg_mask[r]);
            do_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5), $urandom);
        end
    endtask

    initial begin
        #12;
        check_eq("rst_cs", 32'(s_cs_n), 32'h1f);
        check_eq("rst_ready", 32'(m_ready), 32'd0);
        check_eq("rst_err", 32'(m_err), 32'd0);
        check_eq("rst_rdata", m_rdata, 32'd0);
        check_eq("rst_saddr", s_addr, 32'd0);
        check_eq("rst_swe", 32'(s_we), 32'd0);
        check_eq("rst_swdata", s_wdata, 32'd0);
        check_eq("rst_sbe", 32'(s_be), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        do_txn(32'h3000_0010, 1'b0, 32'h0, 4'hf, 0, 32'h1234_5678);   // DMEM alias
        do_txn(32'h8000_2004, 1'b1, 32'hA5A5_0F0F, 4'b0011, 3, 32'h0); // GPIO, ready at limit
        do_txn(32'h5000_0000, 1'b0, 32'h0, 4'hf, 0, 32'h0);            // unmapped
        do_txn(32'h8000_1000, 1'b0, 32'h0, 4'hf, 100, 32'h0);          // TIMER hangs
        do_txn(32'h1000_0100, 1'b0, 32'h0, 4'hf, 1, 32'h0BAD_F00D);    // follow-up

        run_random(150);

        // Reset in the middle of an access drops chip select without a clock.
        m_req = 1'b1; m_addr = 32'h8000_1000; m_we = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_cs_before", 32'(s_cs_n), 32'h17);
        m_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_cs_async", 32'(s_cs_n), 32'h1f);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("rst_mid_no_ready", 32'(m_ready), 32'd0);
            check_eq("rst_mid_cs_idle", 32'(s_cs_n), 32'h1f);
        end

        // Overlapping map: slave 0 must beat UART; UART's ready must be ignored.
        m_req = 1'b1; m_addr = 32'h8000_0000; m_we = 1'b0; s_ready2 = '0;
        @(posedge clk); #1;
        check_eq("ovr_cs", 32'(s_cs_n2), 32'h1e);
        check_eq("def_uart_cs", 32'(s_cs_n), 32'h0f);
        s_ready2 = 5'b10000;
        s_rdata[31:0] = 32'hCAFE_0001;
        @(posedge clk); #1;
        check_eq("ovr_ignore_ready", 32'(m_ready2), 32'd0);
        check_eq("ovr_cs_hold", 32'(s_cs_n2), 32'h1e);
        s_ready2 = 5'b00001;
        @(posedge clk); #1;
        check_eq("ovr_ready", 32'(m_ready2), 32'd1);
        check_eq("ovr_err", 32'(m_err2), 32'd0);
        check_eq("ovr_rdata", m_rdata2, 32'hCAFE_0001);
        m_req = 1'b0; s_ready2 = '0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("final_cs", 32'(s_cs_n), 32'h1f);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_decoder_fsm.md
# bus_decoder_fsm

Parametrised, registered address decoder and response router for the CPU data-bus port. It replaces fixed combinational chip-select decoding with a base/mask region table, a request/ready handshake toward the core, and per-slave ready/read-data muxing. Unmapped accesses and hung slaves return a bus error instead of stalling. It sits between the MEM stage load/store port and the DMEM, TBMAN, GPIO, TIMER and UART slaves.

## Interface
- N_SLV, 5, number of slave ports.
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum cycles in ACCESS before a bus error; must be ≥ 1.
- SLV_BASE, bus_dec_pkg::DEF_BASE, packed N_SLV×AW region bases; slave i uses bits [i*AW +: AW].
- SLV_MASK, bus_dec_pkg::DEF_MASK, packed N_SLV×AW region masks.
- ERR_DATA, 32'hDEAD_BEEF, m_rdata value on error (DW bits).
- clk  in  1  Single clock. All state changes on the rising edge.
- reset_n  in  1  Reset, asynchronous assert, active-low.
- m_req  in  1  Core request. Held high until m_ready.
- m_addr  in  AW  Request address.
- m_we  in  1  1 = write, 0 = read.
- m_wdata  in  DW  Write data.
- m_be  in  DW/8  Byte enables.
- m_ready  out  1  One-cycle completion pulse.
- m_err  out  1  Error flag. Valid only while m_ready is high.
- m_rdata  out  DW  Read data. Valid only while m_ready is high.
- s_cs_n  out  N_SLV  Active-low chip select, one bit per slave.
- s_addr, s_we, s_wdata, s_be  out  AW/1/DW/DW/8  Captured request, broadcast to all slaves.
- s_ready  in  N_SLV  Per-slave completion.
- s_rdata  in  N_SLV×DW  Per-slave read data, packed.

## Operation
- Match rule: slave i hits when (addr & SLV_MASK[i]) == SLV_BASE[i]. On overlapping regions, the lowest index wins.
- FSM states and transitions:
  - IDLE: if m_req is high, capture addr/we/wdata/be and the match result.
    - Hit → ACCESS.
    - Miss → ERR.
    - m_req low → stay in IDLE.
  - ACCESS: drive s_cs_n[sel] low; all other chip selects stay high.
    - If s_ready[sel] is high, latch s_rdata[sel] and go to RESP.
    - Otherwise, if the wait counter equals TIMEOUT-1, go to ERR.
    - Otherwise, increment the counter.
  - RESP: m_ready=1, m_err=0, m_rdata = latched data (0 for writes) → IDLE.
  - ERR: m_ready=1, m_err=1, m_rdata = ERR_DATA → IDLE.
- The wait counter is cleared on entry to ACCESS. Its width is $clog2(TIMEOUT+1).
- s_ready from unselected slaves is ignored.
- If s_ready and timeout occur in the same cycle, s_ready wins.
- m_req is ignored outside IDLE. Changing m_addr mid-transaction has no effect because the request is captured.
- Exactly one chip select is low, or none. No chip select is low in IDLE, RESP or ERR.

## Timing
- Reset values: state IDLE, s_cs_n all ones, m_ready 0, m_err 0, m_rdata 0, s_addr/s_we/s_wdata/s_be 0, counter 0.
- Reset asserted mid-ACCESS releases s_cs_n asynchronously. No response is issued for the aborted transaction.
- Request sampled at edge k (hit, slave ready in its first cycle):
  - s_cs_n low during cycle k+1.
  - m_ready high during cycle k+2.
  - Minimum latency is 2 cycles; a new request is accepted at edge k+3.
- Miss sampled at edge k: m_ready=1 and m_err=1 during cycle k+1. s_cs_n never asserts.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then ERR for one cycle.
- All outputs are registered; there is no combinational path from m_* to s_cs_n.

## Structure
- bus_dec_pkg holds:
  - The state enum: IDLE, ACCESS, RESP, ERR.
  - Slave index constants: DMEM=0, TBMAN=1, GPIO=2, TIMER=3, UART=4.
  - DEF_BASE = {0x8000_0000, 0x8000_1000, 0x8000_2000, 0x8000_F000, 0x1000_0000}, listed MSB-first.
  - DEF_MASK = {0xFFFF_F000 ×4, 0xD000_0000}. The DMEM mask covers both the 0x1xxx_xxxx and 0x3xxx_xxxx ranges.
- Sub-module bus_dec_match: combinational region compare plus priority encoder, producing hit and sel[$clog2(N_SLV)-1:0].

## Test plan
- Read 0x3000_0010 with default map; DMEM raises s_ready in its first cycle with data 0x1234_5678 → s_cs_n=5'b11110 for one cycle; m_ready two cycles after the sampling edge; m_rdata=0x1234_5678; m_err=0.
- Write 0x8000_2004, be=4'b0011; GPIO waits 3 cycles → s_cs_n=5'b11011 for 4 cycles; s_wdata/s_be stable throughout; m_ready pulse with m_err=0.
- Read 0x5000_0000 (unmapped) → no chip select; m_ready=1, m_err=1, m_rdata=0xDEAD_BEEF one cycle after sampling.
- TIMER never readies with TIMEOUT=4 → s_cs_n[3] low for exactly 4 cycles, then error response; a follow-up request is accepted normally.
- Override maps with slave 0 region 0x8000_0000/0xFFFF_0000 overlapping UART; access 0x8000_0000 → slave 0 selected. Also: s_ready from a non-selected slave is ignored.
- Assert reset_n low during ACCESS → s_cs_n all ones immediately; after release, no m_ready pulse until a new request arrives.
